// File: rtl/dmem_responder.sv
// dmem_responder: word-indexed data memory with valid/ready request and response handshakes.
// Latency: response registered WAIT_CYCLES edges after accept; response held until rsp_ready. Option: DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_W     = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = DEPTH_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_W)-1];

    logic              a_rd, a_wr;
    logic [AW-1:0]     a_addr;
    logic [2:0]        a_f3;
    logic [DATA_W-1:0] a_wdata;
    logic [DEPTH_W-1:0] idx;
    logic [1:0]        off;
    logic              is_half, is_word, misalign, acc_err;
    logic [DATA_W-1:0] cur, st_val, ld_val;
    logic [31:0]       ld32;
    logic              enter_resp, mem_we;
    logic              unused_addr;

    assign unused_addr = &{1'b0, req_addr[31:AW]};

    // With zero wait states the access resolves on its own accept edge, so decode the live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            a_rd    = MemRead;
            a_wr    = MemWrite;
            a_addr  = req_addr[AW-1:0];
            a_f3    = Funct3;
            a_wdata = req_wdata;
        end else begin
            a_rd    = rd_q;
            a_wr    = wr_q;
            a_addr  = addr_q;
            a_f3    = f3_q;
            a_wdata = wdata_q;
        end
    end

    always_comb begin
        idx     = a_addr[AW-1:2];
        is_half = (a_f3[1:0] == 2'b01);
        is_word = (a_f3 == 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = (is_half && a_addr[0]) || (is_word && (a_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = (a_rd || a_wr) &&
                  ((a_rd && a_wr) || (a_f3 == 3'b011) || (a_f3[2:1] == 2'b11) ||
                   (a_wr && a_f3[2]) || misalign);
        if (is_word)      off = 2'b00;
        else if (is_half) off = {a_addr[1], 1'b0};
        else              off = a_addr[1:0];
        cur    = mem[idx];
        st_val = cur;
        ld32   = 32'h0;
        case (a_f3[1:0])
            2'b00: begin
                st_val[{off, 3'b000} +: 8] = a_wdata[7:0];
                ld32 = {{24{~a_f3[2] & cur[{off, 3'b111}]}}, cur[{off, 3'b000} +: 8]};
            end
            2'b01: begin
                st_val[{off, 3'b000} +: 16] = a_wdata[15:0];
                ld32 = {{16{~a_f3[2] & cur[{off, 3'b000} + 5'd15]}}, cur[{off, 3'b000} +: 16]};
            end
            default: begin
                st_val[31:0] = a_wdata[31:0];
                ld32 = cur[31:0];
            end
        endcase
        if (a_rd && !acc_err) ld_val = DATA_W'($signed(ld32));
        else                  ld_val = '0;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        enter_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    addr_d  = req_addr[AW-1:0];
                    f3_d    = Funct3;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) enter_resp = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = ld_val;
        end
        req_ready_d = (state_d == IDLE);
    end

    assign mem_we = reset && enter_resp && a_wr && !acc_err;

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= st_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            f3_q        <= 3'b000;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/backpressure sequences, random traffic vs a byte-lane model.
module tb_dmem_responder;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] mem_m [256];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rdat;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .DEPTH_W(8), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .req_addr(req_addr), .Funct3(Funct3),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: whole-word array updated with masks and shifts per access size.
    task automatic ref_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                              input logic [31:0] wd, output bit e, output logic [31:0] rv);
        int idx, nb, off;
        logic [31:0] mask, v;
        e = 1'b0;
        rv = 32'h0;
        if (!rd && !wr) return;
        if ((rd && wr) || f3 == 3 || f3 == 6 || f3 == 7 || (wr && f3 >= 4)) begin
            e = 1'b1;
            return;
        end
        nb  = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        idx = (addr / 4) % 256;
        off = addr % 4;
        if (off % nb != 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
            e = 1'b1;
            return;
`else
            off = off - off % nb;
`endif
        end
        mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        if (wr) begin
            mem_m[idx] = (mem_m[idx] & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
        end else begin
            v = (mem_m[idx] >> (8 * off)) & mask;
            if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
            rv = v;
        end
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] wd, input int hold, output bit ge, output logic [31:0] gr);
        int edges;
        @(negedge clk);
        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1; MemRead = rd; MemWrite = wr;
        req_addr = addr; Funct3 = f3; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        chk("busy_after_accept", {req_ready, rsp_valid, rsp_rdata}, 64'h0);
        // Count edges after the accept edge until the response appears.
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, WAITC);
        ge = rsp_err;
        gr = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("resp_hold", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {1'b1, 1'b0, ge, gr});
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("resp_release", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [21];
        bit          e, me;
        logic [31:0] r, mr;
        int          edges;

        vt[0]  = '{0, 1, 32'h10,  3'd2, 32'hDEADBEEF, 0, 32'h0};
        vt[1]  = '{1, 0, 32'h10,  3'd2, 32'h0,        0, 32'hDEADBEEF};
        vt[2]  = '{0, 1, 32'h21,  3'd0, 32'h80,       0, 32'h0};
        vt[3]  = '{1, 0, 32'h21,  3'd0, 32'h0,        0, 32'hFFFFFF80};
        vt[4]  = '{1, 0, 32'h21,  3'd4, 32'h0,        0, 32'h00000080};
        vt[5]  = '{1, 0, 32'h20,  3'd2, 32'h0,        0, 32'h00008000};
        vt[6]  = '{1, 0, 32'h20,  3'd1, 32'h0,        0, 32'hFFFF8000};
        vt[7]  = '{1, 0, 32'h22,  3'd5, 32'h0,        0, 32'h0};
`ifdef DMEM_MISALIGN_CHECK_EN
        vt[8]  = '{1, 0, 32'h12,  3'd2, 32'h0,        1, 32'h0};
`else
        vt[8]  = '{1, 0, 32'h12,  3'd2, 32'h0,        0, 32'hDEADBEEF};
`endif
        vt[9]  = '{0, 1, 32'h400, 3'd2, 32'h12345678, 0, 32'h0};
        vt[10] = '{1, 0, 32'h000, 3'd2, 32'h0,        0, 32'h12345678};
        vt[11] = '{1, 1, 32'h000, 3'd2, 32'hFFFFFFFF, 1, 32'h0};
        vt[12] = '{1, 0, 32'h000, 3'd2, 32'h0,        0, 32'h12345678};
        vt[13] = '{0, 1, 32'h000, 3'd5, 32'h0000FFFF, 1, 32'h0};
        vt[14] = '{1, 0, 32'h000, 3'd3, 32'h0,        1, 32'h0};
        vt[15] = '{0, 0, 32'h000, 3'd2, 32'hFFFFFFFF, 0, 32'h0};
`ifdef DMEM_MISALIGN_CHECK_EN
        vt[16] = '{0, 1, 32'h403, 3'd1, 32'h0000BEEF, 1, 32'h0};
        vt[17] = '{1, 0, 32'h000, 3'd2, 32'h0,        0, 32'h12345678};
`else
        vt[16] = '{0, 1, 32'h403, 3'd1, 32'h0000BEEF, 0, 32'h0};
        vt[17] = '{1, 0, 32'h000, 3'd2, 32'h0,        0, 32'hBEEF5678};
`endif
        vt[18] = '{0, 1, 32'h13,  3'd0, 32'h0000007F, 0, 32'h0};
        vt[19] = '{1, 0, 32'h13,  3'd0, 32'h0,        0, 32'h0000007F};
        vt[20] = '{1, 0, 32'h12,  3'd1, 32'h0,        0, 32'h00007FAD};

        #3;
        chk("reset_outputs", {rsp_valid, rsp_err, rsp_rdata}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});

        for (int i = 0; i < 256; i++) begin
            do_access(1'b0, 1'b1, i * 4, 3'd2, 32'h0, 0, e, r);
            mem_m[i] = 32'h0;
        end

        for (int i = 0; i < 21; i++) begin
            do_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].f3, vt[i].wd, 0, e, r);
            ref_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].f3, vt[i].wd, me, mr);
            chk($sformatf("vec%0d", i), {e, r}, {vt[i].err, vt[i].rdat});
        end

        // Response held under backpressure for five cycles.
        ref_access(1'b1, 1'b0, 32'h10, 3'd2, 32'h0, me, mr);
        do_access(1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 5, e, r);
        chk("hold_load", {e, r}, {me, mr});

        // Reset during the wait of a store: no write must land.
        @(negedge clk);
        req_valid = 1'b1; MemWrite = 1'b1; req_addr = 32'h40; Funct3 = 3'd2; req_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        req_valid = 1'b0; MemWrite = 1'b0;
        #2 reset = 1'b0;
        #1 chk("reset_in_wait", {rsp_valid, rsp_err, rsp_rdata}, 64'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ref_access(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, me, mr);
        do_access(1'b1, 1'b0, 32'h40, 3'd2, 32'h0, 0, e, r);
        chk("aborted_store", {e, r}, {me, mr});

        // Reset while a response is being presented clears it at once.
        @(negedge clk);
        req_valid = 1'b1; MemRead = 1'b1; req_addr = 32'h10; Funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0;
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("resp_before_reset", {rsp_valid, rsp_rdata}, {1'b1, mem_m[4]});
        #2 reset = 1'b0;
        #1 chk("reset_in_resp", {rsp_valid, rsp_err, rsp_rdata}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 300; n++) begin
            int          sel, hold;
            bit          rd, wr;
            logic [31:0] addr, wd;
            logic [2:0]  f3;
            sel  = $urandom_range(0, 9);
            rd   = (sel <= 3) || (sel == 8);
            wr   = (sel >= 4 && sel <= 8);
            addr = $urandom_range(0, 32'h7FF);
            f3   = 3'($urandom_range(0, 7));
            wd   = $urandom;
            hold = $urandom_range(0, 2);
            ref_access(rd, wr, addr, f3, wd, me, mr);
            do_access(rd, wr, addr, f3, wd, hold, e, r);
            chk($sformatf("rand%0d rd=%0d wr=%0d a=%h f3=%0d", n, rd, wr, addr, f3), {e, r}, {me, mr});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
